id_stage: RTL

Instruction decode stage of the 5-stage MIPS-lite pipeline, the consumer of the fetch stage's `instruction`/`pc_out` pair and the producer of its `hazard` input. Contains the IF/ID register, a 32x32 register file with writeback bypass, field decode with immediate sign-extension, load-use stall detection, control-instruction duplicate squashing and the ID/EX pipeline register feeding execute.

---
 rtl/id_stage.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Decode stage of the MIPS-lite pipeline: IF/ID register, bypassed register file,
// field decode, load-use stall, control-instruction squash and the ID/EX register.
module id_stage #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_instruction,
  input  logic [31:0]       if_pc,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              hazard,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_dest,
  output logic              id_wr_en,
  output logic [DATA_W-1:0] id_rs_val,
  output logic [DATA_W-1:0] id_rt_val,
  output logic [DATA_W-1:0] id_imm,
  output logic [31:0]       id_pc,
  output logic              id_halt
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned NREGS   = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned IMM_W   = 16;

  localparam logic [OP_W-1:0] OP_ALU_MAX = 6'd11;
  localparam logic [OP_W-1:0] OP_LDW     = 6'd12;
  localparam logic [OP_W-1:0] OP_STW     = 6'd13;
  localparam logic [OP_W-1:0] OP_BZ      = 6'd14;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'd15;
  localparam logic [OP_W-1:0] OP_JR      = 6'd16;
  localparam logic [OP_W-1:0] OP_HALT    = 6'd17;

  // IF/ID register and stage control state
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q,    ifid_pc_d;
  logic [CNT_W-1:0]   squash_q,     squash_d;
  logic               halted_q,     halted_d;

  // ID/EX register
  logic              ex_valid_q,  ex_valid_d;
  logic [OP_W-1:0]   ex_op_q,     ex_op_d;
  logic [REG_W-1:0]  ex_rs_q,     ex_rs_d;
  logic [REG_W-1:0]  ex_rt_q,     ex_rt_d;
  logic [REG_W-1:0]  ex_dest_q,   ex_dest_d;
  logic              ex_wr_q,     ex_wr_d;
  logic [DATA_W-1:0] ex_rs_val_q, ex_rs_val_d;
  logic [DATA_W-1:0] ex_rt_val_q, ex_rt_val_d;
  logic [DATA_W-1:0] ex_imm_q,    ex_imm_d;
  logic [PC_W-1:0]   ex_pc_q,     ex_pc_d;
  logic              ex_halt_q,   ex_halt_d;

  logic [DATA_W-1:0] rf_q [NREGS];

  logic [OP_W-1:0]   dec_op;
  logic [REG_W-1:0]  dec_rs, dec_rt, dec_rd;
  logic [IMM_W-1:0]  dec_imm_raw;
  logic              dec_legal, dec_valid, dec_reads_rs, dec_reads_rt, dec_wr;
  logic              dec_ctrl, fetch_ctrl;
  logic [REG_W-1:0]  dec_dest;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [OP_W-1:0]   fetch_op;

  assign dec_op      = ifid_instr_q[31:26];
  assign dec_rs      = ifid_instr_q[25:21];
  assign dec_rt      = ifid_instr_q[20:16];
  assign dec_rd      = ifid_instr_q[15:11];
  assign dec_imm_raw = ifid_instr_q[15:0];
  assign fetch_op    = if_instruction[31:26];

  // Operand usage and destination selection per opcode class
  always_comb begin
    dec_legal    = 1'b0;
    dec_reads_rs = 1'b0;
    dec_reads_rt = 1'b0;
    dec_wr       = 1'b0;
    dec_dest     = '0;
    if (dec_op <= OP_HALT) dec_legal = 1'b1;
    if (dec_op <= OP_ALU_MAX) begin
      dec_reads_rs = 1'b1;
      dec_wr       = 1'b1;
      if (!dec_op[0]) begin
        dec_reads_rt = 1'b1;
        dec_dest     = dec_rd;
      end else begin
        dec_dest     = dec_rt;
      end
    end else begin
      case (dec_op)
        OP_LDW: begin
          dec_reads_rs = 1'b1;
          dec_wr       = 1'b1;
          dec_dest     = dec_rt;
        end
        OP_STW, OP_BEQ: begin
          dec_reads_rs = 1'b1;
          dec_reads_rt = 1'b1;
        end
        OP_BZ, OP_JR: dec_reads_rs = 1'b1;
        default: ;
      endcase
    end
  end

  assign dec_valid  = ifid_valid_q & dec_legal;
  assign dec_ctrl   = (dec_op == OP_BZ) || (dec_op == OP_BEQ) || (dec_op == OP_HALT);
  assign fetch_ctrl = (fetch_op == OP_BZ) || (fetch_op == OP_BEQ) || (fetch_op == OP_HALT);

  // Register reads see a same-cycle writeback
  assign rs_val = (wb_en && (wb_rd == dec_rs)) ? wb_data : rf_q[dec_rs];
  assign rt_val = (wb_en && (wb_rd == dec_rt)) ? wb_data : rf_q[dec_rt];

  assign hazard = ex_valid_q && (ex_op_q == OP_LDW) && dec_valid && !dec_ctrl &&
                  ((dec_reads_rs && (dec_rs == ex_dest_q)) ||
                   (dec_reads_rt && (dec_rt == ex_dest_q)));

  // IF/ID next state: hold on stall, bubble while squashing or halted
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    squash_d     = squash_q;
    halted_d     = halted_q;
    if (dec_valid && (dec_op == OP_HALT) && !hazard) halted_d = 1'b1;
    if (squash_q != '0) squash_d = squash_q - CNT_W'(1);
    if (!hazard) begin
      if (halted_q || (squash_q != '0)) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = '0;
        ifid_pc_d    = '0;
      end else begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = if_instruction;
        ifid_pc_d    = if_pc;
        if (fetch_ctrl) squash_d = CNT_W'(SQUASH_CYCLES);
      end
    end
  end

  // ID/EX next state: bubble on stall or non-instruction
  always_comb begin
    ex_valid_d  = 1'b0;
    ex_op_d     = '0;
    ex_rs_d     = '0;
    ex_rt_d     = '0;
    ex_dest_d   = '0;
    ex_wr_d     = 1'b0;
    ex_rs_val_d = '0;
    ex_rt_val_d = '0;
    ex_imm_d    = '0;
    ex_pc_d     = '0;
    ex_halt_d   = 1'b0;
    if (dec_valid && !hazard) begin
      ex_valid_d  = 1'b1;
      ex_op_d     = dec_op;
      ex_rs_d     = dec_rs;
      ex_rt_d     = dec_rt;
      ex_dest_d   = dec_dest;
      ex_wr_d     = dec_wr;
      ex_rs_val_d = rs_val;
      ex_rt_val_d = rt_val;
      ex_imm_d    = {{(DATA_W-IMM_W){dec_imm_raw[IMM_W-1]}}, dec_imm_raw};
      ex_pc_d     = ifid_pc_q;
      ex_halt_d   = (dec_op == OP_HALT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      squash_q     <= '0;
      halted_q     <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_op_q      <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_dest_q    <= '0;
      ex_wr_q      <= 1'b0;
      ex_rs_val_q  <= '0;
      ex_rt_val_q  <= '0;
      ex_imm_q     <= '0;
      ex_pc_q      <= '0;
      ex_halt_q    <= 1'b0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      squash_q     <= squash_d;
      halted_q     <= halted_d;
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dest_q    <= ex_dest_d;
      ex_wr_q      <= ex_wr_d;
      ex_rs_val_q  <= ex_rs_val_d;
      ex_rt_val_q  <= ex_rt_val_d;
      ex_imm_q     <= ex_imm_d;
      ex_pc_q      <= ex_pc_d;
      ex_halt_q    <= ex_halt_d;
    end
  end

  // Register file, all 32 entries writable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign id_valid  = ex_valid_q;
  assign id_opcode = ex_op_q;
  assign id_rs     = ex_rs_q;
  assign id_rt     = ex_rt_q;
  assign id_dest   = ex_dest_q;
  assign id_wr_en  = ex_wr_q;
  assign id_rs_val = ex_rs_val_q;
  assign id_rt_val = ex_rt_val_q;
  assign id_imm    = ex_imm_q;
  assign id_pc     = ex_pc_q;
  assign id_halt   = ex_halt_q;

endmodule
